// File: rtl/alloc_encoder_pkg.sv
// Shared defaults and helpers for the free-list allocator.
// Used by alloc_encoder and alloc_encoder_enc via import alloc_encoder_pkg::*.
package alloc_encoder_pkg;

  localparam int ALLOC_SIZE  = 32;
  localparam int ALLOC_WIDTH = 5;
  localparam int ALLOC_NCH   = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/alloc_encoder_enc.sv
// One-hot to binary encoder; an all-zero input yields index 0.
// OR-reduction form, so the input is assumed to have at most one bit set.
module alloc_encoder_enc
  import alloc_encoder_pkg::*;
#(
  parameter int SIZE  = ALLOC_SIZE,
  parameter int WIDTH = ALLOC_WIDTH
) (
  input  logic [SIZE-1:0]  onehot,
  output logic [WIDTH-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (onehot[i]) idx = idx | WIDTH'(i);
    end
  end

endmodule

// File: rtl/alloc_encoder.sv
// Multi-channel free-list allocator: grants the lowest free entries to requesting channels.
// Optional feature: define ALLOC_CNT_EN to add the registered free-entry count o_nfree.
module alloc_encoder
  import alloc_encoder_pkg::*;
#(
  parameter int              SIZE     = ALLOC_SIZE,
  parameter int              WIDTH    = ALLOC_WIDTH,
  parameter int              NCH      = ALLOC_NCH,
  parameter logic [SIZE-1:0] RST_FREE = {SIZE{1'b1}}
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic [NCH-1:0]       i_req,
  output logic [NCH-1:0]       o_vld,
  output logic [NCH*WIDTH-1:0] o_idx,
  input  logic [SIZE-1:0]      i_rel,
  input  logic                 i_flush,
  output logic                 o_empty
`ifdef ALLOC_CNT_EN
  ,
  output logic [WIDTH:0]       o_nfree
`endif
);

  if (WIDTH != clog2(SIZE)) begin : g_width_check
    $error("alloc_encoder: WIDTH must equal clog2(SIZE)");
  end

  logic [SIZE-1:0] free;
  logic [SIZE-1:0] free_nxt;
  logic [SIZE-1:0] alloc_mask;
  logic [SIZE-1:0] avail [NCH+1];
  logic [SIZE-1:0] pick  [NCH];
  logic [NCH-1:0]  vld;

  // Each requesting channel takes the lowest bit still free after the
  // channels below it; pick stays zero when not granted so its index is 0.
  always_comb begin
    avail[0]   = free;
    alloc_mask = '0;
    vld        = '0;
    for (int k = 0; k < NCH; k++) begin
      pick[k]      = '0;
      avail[k + 1] = avail[k];
      if (i_rst_n && i_en && i_req[k] && (|avail[k])) begin
        pick[k]      = avail[k] & (~avail[k] + SIZE'(1));
        vld[k]       = 1'b1;
        avail[k + 1] = avail[k] & ~pick[k];
        alloc_mask   = alloc_mask | pick[k];
      end
    end
  end

  assign o_vld = vld;

  for (genvar k = 0; k < NCH; k++) begin : g_enc
    alloc_encoder_enc #(
      .SIZE  (SIZE),
      .WIDTH (WIDTH)
    ) u_enc (
      .onehot (pick[k]),
      .idx    (o_idx[k*WIDTH +: WIDTH])
    );
  end

  // Release is OR'ed after the allocate clear so it wins on a shared bit.
  assign free_nxt = i_flush ? RST_FREE : ((free & ~alloc_mask) | i_rel);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      free    <= RST_FREE;
      o_empty <= (RST_FREE == '0);
    end else begin
      free    <= free_nxt;
      o_empty <= (free_nxt == '0);
    end
  end

`ifdef ALLOC_CNT_EN
  function automatic logic [WIDTH:0] popcnt(input logic [SIZE-1:0] v);
    logic [WIDTH:0] c;
    c = '0;
    for (int i = 0; i < SIZE; i++) c = c + (WIDTH + 1)'(v[i]);
    return c;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_nfree <= popcnt(RST_FREE);
    else          o_nfree <= popcnt(free_nxt);
  end
`endif

endmodule
